// File: rtl/mem_stage_controller_if.sv
// Data-memory request/ready bus between the memory-stage controller
// (master) and the data memory (slave).
interface mem_stage_controller_if #(
  parameter int N = 32
) ();
  logic         Mem_req;
  logic         Mem_we;
  logic [N-1:0] Mem_addr;
  logic [N-1:0] Mem_wdata;
  logic [N-1:0] Mem_rdata;
  logic         Mem_ready;

  modport master (
    output Mem_req,
    output Mem_we,
    output Mem_addr,
    output Mem_wdata,
    input  Mem_rdata,
    input  Mem_ready
  );

  modport slave (
    input  Mem_req,
    input  Mem_we,
    input  Mem_addr,
    input  Mem_wdata,
    output Mem_rdata,
    output Mem_ready
  );
endinterface

// File: rtl/mem_stage_controller.sv
// MEM-stage controller: PC ownership, branch/jump redirect with flush,
// and data-memory sequencing with stall on a ready handshake.
module mem_stage_controller #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = N'(32'h0040_0000)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Zero,
  input  logic [N-1:0] ALU_result,
  input  logic [N-1:0] Data_2,
  input  logic [N-1:0] Jump_address,
  input  logic [N-1:0] Branch_adress,
  input  logic [N-1:0] RA_address,
  input  logic         Jump,
  input  logic         BranchEQ,
  input  logic         BranchNE,
  input  logic         JR,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic [N-1:0] PC_4_seq,
  output logic [N-1:0] PC,
  output logic         Flush,
  output logic         Stall,
  output logic [N-1:0] Read_data,
  output logic         Addr_error,
  output logic [15:0]  Taken_count,
  mem_stage_controller_if.master mem
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    REDIRECT
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] rd_q, rd_d;
  logic         ae_q, ae_d;
  logic [15:0]  tc_q, tc_d;

  logic         access;
  logic         taken;
  logic         req;
  logic         stall;
  logic         redir;
  logic [N-1:0] target;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      ae_q    <= 1'b0;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      ae_q    <= ae_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    access = MemRead | MemWrite;
    taken  = JR | Jump | (BranchEQ & Zero)
           | (BranchNE & ~Zero);
    // Gating with reset drops the request the moment reset asserts
    req    = reset & access & (state_q != REDIRECT);
    stall  = req & ~mem.Mem_ready;
    redir  = reset & taken & ~stall
           & (state_q != REDIRECT);

    target = Branch_adress;
    priority case (1'b1)
      JR:      target = RA_address;
      Jump:    target = Jump_address;
      default: target = Branch_adress;
    endcase

    state_d = state_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    ae_d    = ae_q;
    tc_d    = tc_q;

    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (stall) begin
          state_d = MEM_WAIT;
        end else if (redir) begin
          state_d = REDIRECT;
          pc_d    = target;
        end else begin
          state_d = RUN;
          pc_d    = PC_4_seq;
        end
      end
      REDIRECT: begin
        state_d = RUN;
        pc_d    = PC_4_seq;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (req & mem.Mem_ready & MemRead)
      rd_d = mem.Mem_rdata;
    if (req & (ALU_result[1:0] != 2'b00))
      ae_d = 1'b1;
    if (redir & (tc_q != 16'hFFFF))
      tc_d = tc_q + 16'd1;
  end

  assign mem.Mem_req   = req;
  assign mem.Mem_we    = req & MemWrite;
  assign mem.Mem_addr  = {ALU_result[N-1:2], 2'b00};
  assign mem.Mem_wdata = Data_2;

  assign PC          = pc_q;
  assign Flush       = redir;
  assign Stall       = stall;
  assign Read_data   = rd_q;
  assign Addr_error  = ae_q;
  assign Taken_count = tc_q;

endmodule

// File: tb/tb_mem_stage_controller.sv
// Directed vector bench for mem_stage_controller: redirects,
// memory wait states, misalignment and reset during an access.
module tb_mem_stage_controller;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic        Zero, Jump, BranchEQ, BranchNE, JR;
  logic        MemRead, MemWrite;
  logic [31:0] ALU_result, Data_2;
  logic [31:0] Jump_address, Branch_adress, RA_address;
  logic [31:0] PC_4_seq, PC, Read_data;
  logic        Flush, Stall, Addr_error;
  logic [15:0] Taken_count;

  mem_stage_controller_if #(.N(32)) mif ();

  mem_stage_controller #(
    .N(32),
    .RESET_PC(RST_PC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Zero         (Zero),
    .ALU_result   (ALU_result),
    .Data_2       (Data_2),
    .Jump_address (Jump_address),
    .Branch_adress(Branch_adress),
    .RA_address   (RA_address),
    .Jump         (Jump),
    .BranchEQ     (BranchEQ),
    .BranchNE     (BranchNE),
    .JR           (JR),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .PC_4_seq     (PC_4_seq),
    .PC           (PC),
    .Flush        (Flush),
    .Stall        (Stall),
    .Read_data    (Read_data),
    .Addr_error   (Addr_error),
    .Taken_count  (Taken_count),
    .mem          (mif)
  );

  // IF stage feeding PC+4 back
  assign PC_4_seq = PC + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ctl;   // jr jump beq bne zero rd wr rdy
    logic [31:0] alu;
    logic [31:0] d2;
    logic [31:0] ja;
    logic [31:0] ba;
    logic [31:0] ra;
    logic [31:0] rdata;
    logic [3:0]  ecomb; // flush stall req we
    logic [31:0] eaddr;
    logic [31:0] epc;
    logic [31:0] erd;
    logic        eae;
    logic [15:0] etc;
  } vec_t;

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s got=%h want=%h", nm, act, exp);
  endtask

  function automatic vec_t mk(
    logic [7:0] ctl, logic [31:0] alu, logic [31:0] d2,
    logic [31:0] ja, logic [31:0] ba, logic [31:0] ra,
    logic [31:0] rdata, logic [3:0] ecomb,
    logic [31:0] eaddr, logic [31:0] epc,
    logic [31:0] erd, logic eae, logic [15:0] etc);
    vec_t v;
    v.ctl = ctl; v.alu = alu; v.d2 = d2;
    v.ja = ja; v.ba = ba; v.ra = ra; v.rdata = rdata;
    v.ecomb = ecomb; v.eaddr = eaddr; v.epc = epc;
    v.erd = erd; v.eae = eae; v.etc = etc;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    {JR, Jump, BranchEQ, BranchNE, Zero,
     MemRead, MemWrite, mif.Mem_ready} = v.ctl;
    ALU_result    = v.alu;
    Data_2        = v.d2;
    Jump_address  = v.ja;
    Branch_adress = v.ba;
    RA_address    = v.ra;
    mif.Mem_rdata = v.rdata;
  endtask

  vec_t vt[20];
  vec_t idle;

  initial begin
    idle = mk(8'b00000001, 0, 0, 0, 0, 0, 0,
              4'b0000, 0, 0, 0, 1'b0, 0);
    vt[0]  = mk(8'b00000001, 0, 0, 0, 0, 0, 0,
                4'b0000, 0, 32'h0040_0004, 0, 0, 0);
    vt[1]  = mk(8'b00000001, 0, 0, 0, 0, 0, 0,
                4'b0000, 0, 32'h0040_0008, 0, 0, 0);
    vt[2]  = mk(8'b00101001, 0, 0, 0, 32'h0040_0040, 0, 0,
                4'b1000, 0, 32'h0040_0040, 0, 0, 1);
    vt[3]  = mk(8'b00101001, 0, 0, 0, 32'h0040_0080, 0, 0,
                4'b0000, 0, 32'h0040_0044, 0, 0, 1);
    vt[4]  = mk(8'b00100001, 0, 0, 0, 32'h0040_0080, 0, 0,
                4'b0000, 0, 32'h0040_0048, 0, 0, 1);
    vt[5]  = mk(8'b00010001, 0, 0, 0, 32'h0040_0200, 0, 0,
                4'b1000, 0, 32'h0040_0200, 0, 0, 2);
    vt[6]  = mk(8'b00000001, 0, 0, 0, 0, 0, 0,
                4'b0000, 0, 32'h0040_0204, 0, 0, 2);
    vt[7]  = mk(8'b11000001, 0, 0, 32'h0040_0300, 0,
                32'h0040_0100, 0,
                4'b1000, 0, 32'h0040_0100, 0, 0, 3);
    vt[8]  = mk(8'b00000001, 0, 0, 0, 0, 0, 0,
                4'b0000, 0, 32'h0040_0104, 0, 0, 3);
    vt[9]  = mk(8'b01000001, 0, 0, 32'h0040_0300, 0, 0, 0,
                4'b1000, 0, 32'h0040_0300, 0, 0, 4);
    vt[10] = mk(8'b00000001, 0, 0, 0, 0, 0, 0,
                4'b0000, 0, 32'h0040_0304, 0, 0, 4);
    vt[11] = mk(8'b00000100, 32'h1001_0004, 0, 0, 0, 0, 0,
                4'b0110, 32'h1001_0004, 32'h0040_0304, 0, 0, 4);
    vt[12] = vt[11];
    vt[13] = vt[11];
    vt[14] = mk(8'b00000101, 32'h1001_0004, 0, 0, 0, 0,
                32'hDEAD_BEEF, 4'b0010, 32'h1001_0004,
                32'h0040_0308, 32'hDEAD_BEEF, 0, 4);
    vt[15] = mk(8'b00000011, 32'h1001_0006, 32'h1234_5678,
                0, 0, 0, 0, 4'b0011, 32'h1001_0004,
                32'h0040_030C, 32'hDEAD_BEEF, 1, 4);
    vt[16] = mk(8'b00000001, 0, 0, 0, 0, 0, 0,
                4'b0000, 0, 32'h0040_0310,
                32'hDEAD_BEEF, 1, 4);
    vt[17] = mk(8'b00000101, 32'h1001_0008, 0, 0, 0, 0,
                32'hCAFE_F00D, 4'b0010, 32'h1001_0008,
                32'h0040_0314, 32'hCAFE_F00D, 1, 4);
    vt[18] = mk(8'b00000010, 32'h1001_000C, 32'hA5A5_0001,
                0, 0, 0, 32'h1111_1111, 4'b0111,
                32'h1001_000C, 32'h0040_0314,
                32'hCAFE_F00D, 1, 4);
    vt[19] = mk(8'b00000011, 32'h1001_000C, 32'hA5A5_0001,
                0, 0, 0, 32'h1111_1111, 4'b0011,
                32'h1001_000C, 32'h0040_0318,
                32'hCAFE_F00D, 1, 4);

    // Reset held with an access and a jump pending
    reset = 1'b0;
    apply(mk(8'b10000100, 32'h1001_0004, 0, 0, 0,
             32'h0040_0900, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", 128'({Flush, Stall, mif.Mem_req,
                           mif.Mem_we}), 128'(4'b0000));
    chk("reset_regs", 128'({PC, Read_data, Addr_error,
                            Taken_count}),
        128'({RST_PC, 32'h0, 1'b0, 16'h0}));

    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      apply(vt[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_comb", i),
          128'({Flush, Stall, mif.Mem_req, mif.Mem_we,
                mif.Mem_addr, mif.Mem_wdata}),
          128'({vt[i].ecomb, vt[i].eaddr, vt[i].d2}));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_regs", i),
          128'({PC, Read_data, Addr_error, Taken_count}),
          128'({vt[i].epc, vt[i].erd, vt[i].eae,
                vt[i].etc}));
    end

    // Reset asserted while waiting on memory
    apply(mk(8'b00000100, 32'h1001_0004, 0, 0, 0, 0, 0,
             0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("midrst_pre_stall", 128'({Stall, mif.Mem_req}),
        128'(2'b11));
    @(posedge clk);
    #1;
    chk("midrst_wait_pc", 128'(PC), 128'(32'h0040_0318));
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_ctl", 128'({Flush, Stall, mif.Mem_req,
                            mif.Mem_we}), 128'(4'b0000));
    chk("midrst_regs", 128'({PC, Read_data, Addr_error,
                             Taken_count}),
        128'({RST_PC, 32'h0, 1'b0, 16'h0}));
    #1;
    reset = 1'b1;
    apply(idle);
    @(posedge clk);
    #1;
    chk("post_rst_pc", 128'(PC), 128'(32'h0040_0004));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/mem_stage_controller.md
# mem_stage_controller

Memory-stage controller of the pipelined MIPS core, sitting directly downstream of the EX/MEM pipeline register and consuming its outputs. It resolves jumps and branches, owns the program counter, issues the pipeline flush on a taken control transfer, and sequences data-memory accesses over a ready/request handshake, stalling the pipeline while memory is busy. Read data is captured here for the MEM/WB register.

## Interface
- N, 32, datapath and address width
- RESET_PC, 32'h0040_0000, PC value loaded on reset

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low
- Zero, ALU_result[N], Data_2[N], Jump_address[N], Branch_adress[N], RA_address[N]  input  fields from EX/MEM
- Jump, BranchEQ, BranchNE, JR, MemRead, MemWrite  input  1 each  control from EX/MEM
- PC_4_seq  input  N  sequential next PC from IF (PC+4)
- Mem_rdata  input  N  data memory read data
- Mem_ready  input  1  data memory completes the current access this cycle
- PC  output  N  registered program counter
- Flush  output  1  clear IF/ID, ID/EX, EX/MEM on the next edge
- Stall  output  1  hold PC and all pipeline registers this cycle
- Mem_req, Mem_we  output  1 each  access request / write enable
- Mem_addr, Mem_wdata  output  N  word address (bits[1:0] forced 0) / write data
- Read_data  output  N  registered last completed read data
- Addr_error  output  1  sticky: misaligned access seen
- Taken_count  output  16  count of taken control transfers, saturating

## Operation
- Reset: PC=RESET_PC, state RUN, Read_data=0, Addr_error=0, Taken_count=0; Flush, Stall, Mem_req, Mem_we = 0 while reset is low.
- States: RUN, MEM_WAIT, REDIRECT.
- access = MemRead | MemWrite; taken = JR | Jump | (BranchEQ & Zero) | (BranchNE & ~Zero).
- Mem_req = access in RUN or MEM_WAIT; Mem_we = MemWrite & Mem_req; Mem_addr = {ALU_result[N-1:2],2'b00}; Mem_wdata = Data_2.
- Stall = Mem_req & ~Mem_ready (combinational).
- RUN: access & ~Mem_ready -> MEM_WAIT; taken -> REDIRECT; else stay.
- MEM_WAIT: Mem_req held with stable address/data (EX/MEM is frozen by Stall); Mem_ready -> RUN.
- On any cycle with Mem_req & Mem_ready & MemRead: Read_data <= Mem_rdata.
- Access with ALU_result[1:0] != 0: Addr_error set (cleared only by reset); access still performed on the aligned word.
- Redirect (RUN & taken): PC <= target, Flush=1 combinationally this cycle, Taken_count += 1 (saturate at 16'hFFFF), next state REDIRECT. Target priority JR (RA_address) > Jump (Jump_address) > branch (Branch_adress).
- REDIRECT: one-cycle state; taken ignored (EX/MEM holds a bubble); Flush=0; PC <= PC_4_seq; -> RUN.
- RUN without taken or stall: PC <= PC_4_seq. Stall: PC holds.
- Simultaneous access and taken cannot come from one legal instruction; if both are asserted, access is served first (taken ignored while Stall=1, evaluated once Stall drops).
- Reset mid-access: state forced to RUN, Mem_req drops immediately, partial access abandoned.

## Timing
- Zero-wait memory: Mem_ready high in the request cycle -> no stall, Read_data valid after that edge.
- k wait cycles: Stall high for k cycles, Read_data updated on the edge where Mem_ready is sampled high.
- Taken transfer: Flush in the same cycle EX/MEM presents it; PC=target after that edge; three younger instructions discarded (3-cycle penalty).
- Taken_count updates on the redirect edge.

## Test plan
- Reset release: PC=32'h0040_0000, all outputs 0; free-run with PC_4_seq=PC+4 -> PC advances by 4 each cycle.
- BranchEQ=1, Zero=1, Branch_adress=32'h0040_0040 -> Flush=1 one cycle, PC=32'h0040_0040 next, Taken_count=1; Zero=0 -> no flush, sequential PC.
- JR=1 and Jump=1 together, RA_address=32'h0040_0100 -> PC=32'h0040_0100.
- MemRead, ALU_result=32'h1001_0004, Mem_ready low 3 cycles then high with Mem_rdata=32'hDEAD_BEEF -> Stall 3 cycles, PC frozen, Read_data=32'hDEAD_BEEF.
- MemWrite, ALU_result=32'h1001_0006 -> Mem_addr=32'h1001_0004, Mem_we=1, Addr_error=1 and stays set.
- Reset asserted during MEM_WAIT -> Mem_req and Stall drop immediately, PC=RESET_PC.
